// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared widths, SPI sampler FSM state type and the
//               offset-binary to two's-complement helper.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

  localparam int SAMPLE_W = 12;  // ADC data bits
  localparam int FRAME_W  = 16;  // SPI bits per conversion frame
  localparam int LEAD_W   = 4;   // leading zeros ahead of the data

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } adc_state_t;

  // Mid-scale code 0x800 maps to zero; only the MSB needs inverting.
  function automatic logic signed [SAMPLE_W-1:0] ob2tc(input logic [SAMPLE_W-1:0] code);
    return {~code[SAMPLE_W-1], code[SAMPLE_W-2:0]};
  endfunction

endpackage : adc_pkg
`default_nettype wire

// File: rtl/adc_spi_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_sampler_if
// Description : ADC serial pins, sample output and status of the sampler.
//               slave = the sampler itself, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_spi_sampler_if;
  import adc_pkg::*;

  logic                       en;
  logic                       adc_sdo;
  logic                       adc_cs_n;
  logic                       adc_sclk;
  logic signed [SAMPLE_W-1:0] dout;
  logic                       pls20k;
  logic                       busy;
  logic                       frm_err;

  modport slave (
    input  en, adc_sdo,
    output adc_cs_n, adc_sclk, dout, pls20k, busy, frm_err
  );

  modport master (
    output en, adc_sdo,
    input  adc_cs_n, adc_sclk, dout, pls20k, busy, frm_err
  );

endinterface : adc_spi_sampler_if
`default_nettype wire

// File: rtl/adc_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : adc_tick_gen
// Description : Free-running 0..PERIOD-1 counter with a one-cycle tick on
//               the last count. Usable for any rate strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_tick_gen #(
  parameter int PERIOD = 2500
) (
  input  wire logic clk,
  input  wire logic rst,
  output logic      tick
);

  localparam int                 c_CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(PERIOD - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Period counter, wraps on the last count irrespective of any enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_cnt <= '0;
    else if (r_cnt == c_LAST) r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == c_LAST);

endmodule : adc_tick_gen
`default_nettype wire

// File: rtl/adc_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_sampler
// Description : Generates the sample tick, reads a 16-bit AD7476-style frame
//               over SPI (CPOL=1, sampled on SCLK rising) and presents a
//               signed 12-bit sample with a PLS_W-cycle strobe.
//               Optional macro ADC_FRAME_CHECK_EN: frames with non-zero
//               leading bits keep the previous sample and set sticky frm_err.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int FS_HZ    = 20000,
  parameter int SCLK_DIV = 4,
  parameter int PLS_W    = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  adc_spi_sampler_if.slave  bus
);

  localparam int c_PERIOD  = CLK_HZ / FS_HZ;
  localparam int c_LATENCY = 4 + 2 * FRAME_W * SCLK_DIV;
  localparam int c_DIV_W   = $clog2(SCLK_DIV + 1);
  localparam int c_HALF_W  = $clog2(2 * FRAME_W);

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(SCLK_DIV - 1);
  localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(2 * FRAME_W - 1);
  localparam logic [3:0]          c_PLS_LAST  = 4'(PLS_W - 1);

  // A tick may never land while a frame or its strobe is still running.
  if (c_PERIOD <= c_LATENCY + PLS_W) begin : g_period_chk
    $error("adc_spi_sampler: sample period too short for one frame plus strobe");
  end
  if (PLS_W < 1 || PLS_W > 15) begin : g_pls_chk
    $error("adc_spi_sampler: PLS_W must lie in 1..15");
  end

  adc_state_t                 r_state;
  adc_state_t                 w_state_nxt;
  logic                       w_tick;
  logic                       r_setup;
  logic [c_DIV_W-1:0]         r_div;
  logic [c_HALF_W-1:0]        r_half;
  logic                       w_div_last;
  logic                       w_last_half;
  logic [FRAME_W-1:0]         r_raw;
  logic                       r_cs_n;
  logic                       r_sclk;
  logic                       r_busy;
  logic                       r_pls;
  logic [3:0]                 r_pls_cnt;
  logic signed [SAMPLE_W-1:0] r_dout;
  logic                       w_cs_n_nxt;
  logic                       w_busy_nxt;
  logic                       w_load;
  logic                       w_lead_ok;

  adc_tick_gen #(
    .PERIOD (c_PERIOD)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_div_last  = (r_div == c_DIV_LAST);
  assign w_last_half = (r_half == c_HALF_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state: en is only looked at on the period tick.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_tick && bus.en)           w_state_nxt = SETUP;
      SETUP:   if (r_setup)                    w_state_nxt = SHIFT;
      SHIFT:   if (w_div_last && w_last_half)  w_state_nxt = HOLD;
      HOLD:                                    w_state_nxt = DONE;
      DONE:                                    w_state_nxt = IDLE;
      default:                                 w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so the pins come straight from flops.
  always_comb begin
    w_cs_n_nxt = !((w_state_nxt == SETUP) || (w_state_nxt == SHIFT));
    w_busy_nxt = (w_state_nxt == SETUP) || (w_state_nxt == SHIFT) || (w_state_nxt == HOLD);
    w_load     = (w_state_nxt == DONE);
  end

  // Chip select and busy flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cs_n <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_cs_n <= w_cs_n_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  // Setup delay flag and SCLK half-period / half-count timers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_setup <= 1'b0;
      r_div   <= '0;
      r_half  <= '0;
    end else begin
      r_setup <= (r_state == SETUP);
      if (r_state != SHIFT) begin
        r_div  <= '0;
        r_half <= '0;
      end else if (w_div_last) begin
        r_div  <= '0;
        r_half <= r_half + 1'b1;
      end else begin
        r_div  <= r_div + 1'b1;
      end
    end
  end

  // SCLK idles high, starts each frame with a low half and toggles every SCLK_DIV cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_sclk <= 1'b1;
    else if (w_state_nxt != SHIFT) r_sclk <= 1'b1;
    else if (r_state != SHIFT)     r_sclk <= 1'b0;
    else if (w_div_last)           r_sclk <= ~r_sclk;
  end

  // Capture SDO MSB first on the cycle SCLK rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_raw <= '0;
    else if ((r_state == SHIFT) && w_div_last && !r_sclk)
      r_raw <= {r_raw[FRAME_W-2:0], bus.adc_sdo};
  end

`ifdef ADC_FRAME_CHECK_EN
  logic r_frm_err;

  assign w_lead_ok = (r_raw[FRAME_W-1 -: LEAD_W] == '0);

  // Sticky frame error, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_frm_err <= 1'b0;
    else if (w_load && !w_lead_ok) r_frm_err <= 1'b1;
  end

  assign bus.frm_err = r_frm_err;
`else
  logic w_unused_lead;

  assign w_lead_ok     = 1'b1;
  assign w_unused_lead = |r_raw[FRAME_W-1 -: LEAD_W];
  assign bus.frm_err   = 1'b0;
`endif

  // Sample register and strobe: both change on entry to DONE, strobe width counter saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout    <= '0;
      r_pls     <= 1'b0;
      r_pls_cnt <= '0;
    end else if (w_load) begin
      r_pls     <= 1'b1;
      r_pls_cnt <= c_PLS_LAST;
      if (w_lead_ok) r_dout <= ob2tc(r_raw[SAMPLE_W-1:0]);
    end else if (r_pls) begin
      if (r_pls_cnt == '0) r_pls     <= 1'b0;
      else                 r_pls_cnt <= r_pls_cnt - 1'b1;
    end
  end

  assign bus.adc_cs_n = r_cs_n;
  assign bus.adc_sclk = r_sclk;
  assign bus.busy     = r_busy;
  assign bus.dout     = r_dout;
  assign bus.pls20k   = r_pls;

endmodule : adc_spi_sampler
`default_nettype wire

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Front-end stage that feeds the 12-bit FIR low-pass filter.
- Generates the 20 kHz sample tick and reads a 12-bit serial ADC (AD7476-style 16-bit frame: 4 leading zeros, then 12 data bits MSB first) over SPI.
- Converts straight binary to two's complement and presents a signed 12-bit sample with a strobe (pls20k) directly consumable by the filter's din/pls20k inputs.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- FS_HZ, 20000, sample rate; PERIOD = CLK_HZ/FS_HZ clk cycles (2500 default).
- SCLK_DIV, 4, clk cycles per SCLK half-period (SCLK = 6.25 MHz default).
- PLS_W, 4, pls20k high width in clk cycles (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sampling enable; sampled at each period tick.
- adc_sdo  in  1  ADC serial data.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  SPI clock, idles high (CPOL=1).
- dout  out  12  signed sample, two's complement.
- pls20k  out  1  new-sample strobe, PLS_W cycles high.
- busy  out  1  high while a frame is in progress.
- frm_err  out  1  sticky frame error (see Optional Feature).

Behaviour:
- Reset: adc_cs_n=1, adc_sclk=1, dout=0, pls20k=0, busy=0, frm_err=0; period counter=0; FSM=IDLE. Reset mid-frame aborts the frame immediately; no partial sample is output.
- Period counter counts 0..PERIOD-1 and wraps, free-running regardless of en. Tick = counter==PERIOD-1.
- FSM IDLE -> SETUP: on tick with en=1. adc_cs_n drops on the following cycle; busy=1.
- SETUP: 2 cycles with cs_n low and sclk high, then -> SHIFT.
- SHIFT: 16 SCLK periods.
  - Each period: sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - adc_sdo is sampled into a 16-bit shift register (MSB first) on the clk cycle where sclk goes 0->1.
  - After the 16th high half-period -> HOLD.
- HOLD: 1 cycle, then adc_cs_n=1 -> DONE.
- DONE (1 cycle):
  - dout <= {~raw[11], raw[10:0]} (offset binary to two's complement; 0x800 -> 0).
  - pls20k rises in the same cycle and stays high PLS_W cycles; busy=0; -> IDLE.
- Latency: pls20k rising edge is exactly 4+32*SCLK_DIV cycles after the tick (132 default). Successive pls20k rising edges are exactly PERIOD cycles apart.
- dout is stable between strobes and changes only together with a pls20k rising edge.
- en deasserted mid-frame: the current frame completes and its strobe is issued; no new frame starts. en is checked only at the tick.
- Tick occurring while busy: cannot happen when PERIOD > 4+32*SCLK_DIV+PLS_W. This is an elaboration-time check ($error); no runtime handling.
- pls20k width counter saturates; pls20k never merges across samples.

Optional Feature:
- Macro ADC_FRAME_CHECK_EN.
- Defined:
  - In DONE, if raw[15:12] != 0, dout is held (previous value) and frm_err is set sticky until reset.
  - pls20k is still issued, so downstream timing stays regular.
- Undefined:
  - Leading bits are ignored and dout is always updated.
  - frm_err is tied 0; the port remains present.

Decomposition:
- Shared package adc_pkg:
  - SAMPLE_W=12, FRAME_W=16, LEAD_W=4.
  - FSM state enum {IDLE, SETUP, SHIFT, HOLD, DONE}.
  - Function ob2tc() for offset-binary to two's-complement conversion.
- One natural sub-module: adc_tick_gen (period counter plus tick output), reusable for other rate strobes.
- SPI FSM and output stay in the top module.

Test Plan:
- ADC model returns 0x0FFF / 0x0800 / 0x0000 on successive frames -> dout = 2047, 0, -2048, each with a pls20k rising edge; edges spaced 2500 cycles; first edge 132 cycles after the first tick.
- SPI timing check -> cs_n low 130 cycles per frame; 16 sclk rising edges; sclk high whenever cs_n is high; sdo captured MSB first (pattern 0x0A5A -> dout = 0xA5A ^ 0x800 = 0x25A).
- en=0 at tick -> no cs_n activity and no pls20k that period; dout unchanged. en dropped mid-frame -> that frame still completes with its strobe.
- rst asserted at SCLK edge 7 of a frame -> cs_n=1, sclk=1, dout=0 immediately. After release, the first strobe occurs 2500+132 cycles later (counter restarts at 0).
- With ADC_FRAME_CHECK_EN, frame 0x8123 after a valid sample 0x0400 -> dout stays -1024, frm_err=1 sticky, pls20k still pulses. Without the macro -> dout = 0x123 ^ 0x800, frm_err=0.
- Chained with the FIR filter: constant ADC code 0x0C00 -> filter input is 1024 at 20 kHz; filter output settles to a constant.
